// File: rtl/alu_cmd_issuer_if.sv
// Host-side command/response channels of the ALU command issuer.
// The host drives commands and accepts responses; the issuer is the slave.
interface alu_cmd_issuer_if #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OP_W-1:0]  cmd_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [OP_W-1:0]  rsp_op;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_op
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Front end for the registered-operand ALU: buffers host commands, drives
// operands one cycle ahead of the opcode, and queues results for the host.
module alu_cmd_issuer #(
    parameter int WIDTH     = 16,
    parameter int OP_W      = 3,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_cmd_issuer_if.slave  host,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int RCW = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  op;
    } cmd_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [OP_W-1:0]  op;
    } rsp_t;

    cmd_t           cmd_mem_q [CMD_DEPTH];
    logic [CPW-1:0] cmd_wr_q, cmd_rd_q;
    logic [CPW:0]   cmd_cnt_q, cmd_cnt_d;

    rsp_t           rsp_mem_q [RSP_DEPTH];
    logic [RPW-1:0] rsp_wr_q, rsp_rd_q;
    logic [RCW-1:0] rsp_cnt_q, rsp_cnt_d;

    logic            s1_valid_q;
    logic [OP_W-1:0] op_q;

    logic         cmd_empty, cmd_push, issue, rsp_push, rsp_pop;
    logic [RCW:0] rsp_occ;
    cmd_t         head;

    assign cmd_empty      = (cmd_cnt_q == '0);
    assign host.cmd_ready = (cmd_cnt_q != (CPW+1)'(CMD_DEPTH));
    assign cmd_push       = host.cmd_valid & host.cmd_ready;
    assign head           = cmd_mem_q[cmd_rd_q];

    assign host.rsp_valid = (rsp_cnt_q != '0);
    assign host.rsp_data  = rsp_mem_q[rsp_rd_q].data;
    assign host.rsp_op    = rsp_mem_q[rsp_rd_q].op;
    assign rsp_pop        = host.rsp_valid & host.rsp_ready;
    assign rsp_push       = s1_valid_q;

    // Slots that will be taken after this edge if nothing new issues: a result
    // in flight always lands next edge, so it must already own a slot.
    assign rsp_occ = (RCW+1)'(rsp_cnt_q) + (RCW+1)'(s1_valid_q) - (RCW+1)'(rsp_pop);
    assign issue   = !cmd_empty && (rsp_occ < (RCW+1)'(RSP_DEPTH));

    // Operands follow the FIFO head; the ALU samples them every edge and the
    // opcode register supplies the matching op one cycle later.
    assign alu_a  = cmd_empty ? '0 : head.a;
    assign alu_b  = cmd_empty ? '0 : head.b;
    assign alu_op = op_q;
    assign busy   = !cmd_empty | s1_valid_q | host.rsp_valid;

    // Command FIFO occupancy next state.
    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        case ({cmd_push, issue})
            2'b10:   cmd_cnt_d = cmd_cnt_q + 1'b1;
            2'b01:   cmd_cnt_d = cmd_cnt_q - 1'b1;
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
    end

    // Response buffer occupancy next state.
    always_comb begin
        rsp_cnt_d = rsp_cnt_q;
        case ({rsp_push, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + 1'b1;
            2'b01:   rsp_cnt_d = rsp_cnt_q - 1'b1;
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    // Control state: pointers, counts, issue stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr_q   <= '0;
            cmd_rd_q   <= '0;
            cmd_cnt_q  <= '0;
            rsp_wr_q   <= '0;
            rsp_rd_q   <= '0;
            rsp_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            op_q       <= '0;
        end else begin
            cmd_cnt_q  <= cmd_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            s1_valid_q <= issue;
            if (cmd_push) cmd_wr_q <= cmd_wr_q + 1'b1;
            if (issue) begin
                cmd_rd_q <= cmd_rd_q + 1'b1;
                op_q     <= head.op;
            end
            if (rsp_push)
                rsp_wr_q <= (rsp_wr_q == RPW'(RSP_DEPTH-1)) ? '0 : rsp_wr_q + RPW'(1);
            if (rsp_pop)
                rsp_rd_q <= (rsp_rd_q == RPW'(RSP_DEPTH-1)) ? '0 : rsp_rd_q + RPW'(1);
        end
    end

    // Storage arrays need no reset: validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q] <= {host.cmd_a, host.cmd_b, host.cmd_op};
        if (rsp_push) rsp_mem_q[rsp_wr_q] <= {alu_out, op_q};
    end

    // The issue rule reserves a slot for every in-flight result.
    a_no_rsp_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_push && !rsp_pop && rsp_cnt_q == RCW'(RSP_DEPTH)));
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a registered-operand ALU stub.
module tb_alu_cmd_issuer;
    localparam int WIDTH = 16;
    localparam int OP_W  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [OP_W-1:0]  alu_op;
    logic             busy;

    alu_cmd_issuer #(.WIDTH(WIDTH), .OP_W(OP_W), .CMD_DEPTH(4), .RSP_DEPTH(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .host   (bus),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_out(alu_out),
        .busy   (busy)
    );

    // ALU stub: operands registered each edge, op applied combinationally.
    logic [WIDTH-1:0] sa_q = '0, sb_q = '0;
    always @(posedge clk) begin
        sa_q <= alu_a;
        sb_q <= alu_b;
    end
    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'd0:    alu_out = sa_q + sb_q;
            3'd1:    alu_out = sa_q ^ sb_q;
            3'd2:    alu_out = sa_q << sb_q[3:0];
            default: alu_out = '0;
        endcase
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t tbl[11];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [OP_W-1:0] op, input logic [WIDTH-1:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.cmd_a  = v.a;
        bus.cmd_b  = v.b;
        bus.cmd_op = v.op;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Stream n table entries from base; hold rsp_ready low for 'stall' cycles.
    // All decisions are made at the negedge, so a handshake seen here fires at
    // the following rising edge.
    task automatic run_stream(input int base, input int n, input int stall);
        int sent = 0, got = 0, last_pop = -1, cyc = 0;
        while (got < n && cyc < 60) begin
            bus.rsp_ready = (cyc >= stall);
            if (stall > 0 && cyc == stall) begin
                chk("stall_cmd_ready", 32'(bus.cmd_ready), 0);
                chk("stall_accepted", sent, n);
                chk("stall_rsp_cnt", 32'(dut.rsp_cnt_q), 2);
                chk("stall_cmd_cnt", 32'(dut.cmd_cnt_q), 4);
                chk("stall_head", 32'(bus.rsp_data), 32'(tbl[base].exp));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk($sformatf("rsp%0d_data", base + got), 32'(bus.rsp_data), 32'(tbl[base + got].exp));
                chk($sformatf("rsp%0d_op", base + got), 32'(bus.rsp_op), 32'(tbl[base + got].op));
                if (last_pop >= 0) chk("rsp_gap", cyc - last_pop, 1);
                last_pop = cyc;
                got++;
            end
            if (sent < n) begin
                drive(tbl[base + sent]);
                bus.cmd_valid = 1'b1;
                if (bus.cmd_ready) sent++;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        chk("stream_done", got, n);
        chk("stream_idle_busy", 32'(busy), 0);
        chk("stream_idle_rsp_valid", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int seen;
        tbl[0]  = mk(16'd3,    16'd5,    3'd0, 16'd8);
        tbl[1]  = mk(16'd1,    16'd2,    3'd0, 16'd3);
        tbl[2]  = mk(16'hF0F0, 16'h0FF0, 3'd1, 16'hFF00);
        tbl[3]  = mk(16'd1,    16'd4,    3'd2, 16'h0010);
        tbl[4]  = mk(16'hFFFF, 16'd1,    3'd0, 16'h0000);
        tbl[5]  = mk(16'h0001, 16'h000F, 3'd2, 16'h8000);
        tbl[6]  = mk(16'h1234, 16'h1234, 3'd1, 16'h0000);
        tbl[7]  = mk(16'h8000, 16'h8000, 3'd0, 16'h0000);
        tbl[8]  = mk(16'h00FF, 16'hFF00, 3'd1, 16'hFFFF);
        tbl[9]  = mk(16'h0003, 16'h0010, 3'd2, 16'h0003);
        tbl[10] = mk(16'h7FFF, 16'h0001, 3'd0, 16'h8000);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(tbl[0]);

        // Reset state, observed while reset is held.
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);

        // Single command latency: accept E0, issue E1, capture E2.
        do_reset();
        bus.rsp_ready = 1'b1;
        drive(tbl[0]);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("s1_e0_alu_a", 32'(alu_a), 3);
        chk("s1_e0_alu_b", 32'(alu_b), 5);
        chk("s1_e0_busy", 32'(busy), 1);
        chk("s1_e0_rsp_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("s1_e1_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("s1_e1_alu_a_empty", 32'(alu_a), 0);
        @(negedge clk);
        chk("s1_e2_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("s1_e2_rsp_data", 32'(bus.rsp_data), 8);
        chk("s1_e2_rsp_op", 32'(bus.rsp_op), 0);
        @(negedge clk);
        chk("s1_e3_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("s1_e3_busy", 32'(busy), 0);

        // Back-to-back commands, one response per cycle, in order.
        do_reset();
        run_stream(1, 4, 0);

        // Response side stalled: 2 buffered, 4 queued, then drain 1/cycle.
        do_reset();
        run_stream(5, 6, 10);

        // Full FIFO: push attempt coincides with a pop and is refused.
        do_reset();
        sent = 0;
        for (int c = 0; c < 20 && sent < 6; c++) begin
            drive(tbl[5 + sent]);
            bus.cmd_valid = 1'b1;
            if (bus.cmd_ready) sent++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_head_stable", 32'(bus.rsp_data), 32'(tbl[5].exp));
        drive(tbl[0]);
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        chk("full_cmd_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("full_cmd_ready_rise", 32'(bus.cmd_ready), 1);
        chk("full_cmd_cnt", 32'(dut.cmd_cnt_q), 3);
        chk("full_next_head", 32'(bus.rsp_data), 32'(tbl[6].exp));

        // Pop with the response side fully committed still lets issue proceed.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(tbl[1 + c]);
            bus.cmd_valid = 1'b1;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk("pp_s1_before", 32'(dut.s1_valid_q), 1);
        chk("pp_cnt_before", 32'(dut.rsp_cnt_q), 1);
        chk("pp_head_before", 32'(bus.rsp_data), 32'(tbl[1].exp));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("pp_s1_after", 32'(dut.s1_valid_q), 1);
        chk("pp_cnt_after", 32'(dut.rsp_cnt_q), 1);
        chk("pp_head_after", 32'(bus.rsp_data), 32'(tbl[2].exp));
        @(negedge clk);
        chk("pp_head_last", 32'(bus.rsp_data), 32'(tbl[3].exp));
        @(negedge clk);
        chk("pp_drained", 32'(bus.rsp_valid), 0);

        // Reset mid-operation drops everything.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(tbl[1 + c]);
            bus.cmd_valid = 1'b1;
            if (c < 3) @(negedge clk);
        end
        chk("mr_busy_before", 32'(busy), 1);
        chk("mr_alu_op_before", 32'(alu_op), 1);
        #2;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mr_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_alu_op", 32'(alu_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("mr_no_stale_rsp", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
